mem_arbiter: RTL
================

# mem_arbiter

Shares the single memory port between the instruction-fetch unit and the load/store unit of `cpu_core`. Each requester uses a hold-until-ack handshake. The arbiter sequences one transaction at a time onto the memory bus and returns read data with a one-cycle ack. Load/store has fixed priority, with an optional anti-starvation guard for fetch.

## Interface
- `ADDR_W`, 32, address width for all ports
- `DATA_W`, 32, data width; byte enables are `DATA_W/8` wide
- `STARVE_MAX`, 4, consecutive load/store grants allowed while fetch waits (guard build only), range 1–15

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `if_req` in 1: fetch request, held until `if_ack`
- `if_addr` in ADDR_W: fetch address, stable while `if_req`
- `if_ack` out 1: one-cycle completion pulse
- `if_rdata` out DATA_W: fetched word, valid while `if_ack`
- `ls_req` in 1: load/store request, held until `ls_ack`
- `ls_we` in 1: 1 = store
- `ls_addr` in ADDR_W: load/store address
- `ls_wdata` in DATA_W: store data
- `ls_be` in DATA_W/8: byte enables
- `ls_ack` out 1: one-cycle completion pulse
- `ls_rdata` out DATA_W: load data, valid while `ls_ack`
- `mem_req` out 1: memory request
- `mem_we` out 1: write strobe
- `mem_addr` out ADDR_W: memory address
- `mem_wdata` out DATA_W: memory write data
- `mem_be` out DATA_W/8: memory byte enables
- `mem_ready` in 1: memory completes the transfer in the cycle it is sampled high with `mem_req`
- `mem_rdata` in DATA_W: read data, valid with `mem_ready`
- `busy` out 1: high whenever the state is not IDLE

## Operation
- **FSM states:** IDLE, BUS_IF, BUS_LS, RESP_IF, RESP_LS.
- **IDLE:**
  - `ls_req` → BUS_LS, latching `ls_we`/`ls_addr`/`ls_wdata`/`ls_be`.
  - Else `if_req` → BUS_IF, latching `if_addr` with we=0 and be=all-ones.
  - Else stay in IDLE.
- **BUS_x:**
  - `mem_*` outputs are driven from the latched registers and `mem_req`=1.
  - On `mem_ready`=1, capture `mem_rdata` into the owner's rdata register and go to RESP_x.
  - Otherwise hold; wait states are unbounded.
- **RESP_x:** `x_ack`=1 for exactly one cycle, then IDLE.
  - The requester deasserts or renews `req` at the edge ending RESP.
  - IDLE arbitrates on the new values.
- **Store data:** on a store, `ls_rdata` captures whatever is on `mem_rdata`; its value is don't-care.
- **Requester input changes:** changes to a granted requester's inputs after grant are ignored; the transaction completes from the latched copy.
- **Simultaneous requests in IDLE:** load/store wins, subject to the configured guard.
- **`busy`:** equals state != IDLE.

## Timing
- **Reset values:**
  - All outputs are 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`, `if_ack`, `ls_ack`, `if_rdata`, `ls_rdata`, `busy`.
  - State is IDLE; the starve counter is 0.
- **Latency with zero-wait memory:**
  - `req` seen in IDLE at cycle N.
  - `mem_req` in N+1.
  - `ack` in N+2.
  - A renewed `req` re-arbitrates in N+3, so the minimum transaction spacing is 3 cycles.
- **Wait states:** each cycle of `mem_ready`=0 adds one cycle of latency.
- **`mem_*` outputs:** stable for the whole of BUS_x; `mem_req` is 0 in IDLE and RESP.
- **Reset mid-transaction:** synchronous reset returns the FSM to IDLE at the edge.
  - `mem_req` is 0 in the next cycle.
  - No ack is issued; the aborted transfer is not retried.
  - A `mem_ready` arriving in the reset cycle is ignored.
- **Ack width:** an ack is never asserted for more than one cycle. Both acks are never high together.

## Configuration
- **Macro:** `MEM_ARB_STARVE_GUARD_EN`.
- **Defined:**
  - A 4-bit counter increments on each load/store grant made while `if_req`=1.
  - It clears on any fetch grant, and on a load/store grant made with `if_req`=0.
  - When the counter equals `STARVE_MAX` and both requests are pending in IDLE, fetch is granted.
- **Undefined:** strict load/store priority; the counter is not present.

## Test plan
- **Zero-wait fetch:**
  - Stimulus: `mem_ready`=1 tied; `if_req` with `if_addr`=0x100; `mem_rdata`=0xDEADBEEF.
  - Required: `mem_req` 1 cycle after IDLE sampling with `mem_addr`=0x100, `mem_we`=0, `mem_be`=0xF; `if_ack` 2 cycles after with `if_rdata`=0xDEADBEEF; single-cycle ack.
- **Store with wait states:**
  - Stimulus: `ls_req`, we=1, addr=0x2004, wdata=0x12345678, be=0x3; `mem_ready` low for 3 cycles.
  - Required: `mem_req` held 4 cycles with stable outputs; `ls_ack` the cycle after `mem_ready`.
- **Simultaneous requests, guard undefined:**
  - Stimulus: `if_req` and `ls_req` both asserted, load/store continuously re-requesting.
  - Required: load/store is always granted; `if_ack` never asserted in 20 cycles.
- **Simultaneous requests, guard defined, `STARVE_MAX`=2:**
  - Stimulus: same as the previous scenario.
  - Required: grant sequence LS, LS, IF, LS, LS, IF.
- **Reset mid-transaction:**
  - Stimulus: assert `reset` while in BUS_LS with `mem_ready`=0.
  - Required: next cycle `mem_req`=0, `busy`=0, no `ls_ack`; a subsequent `if_req` is served normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// ---- mem_arbiter_if : requester/memory handshake bundle for mem_arbiter -- rev 1.0 ----
`default_nettype none

interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_ack;
  logic [DATA_W-1:0]     if_rdata;

  logic                  ls_req;
  logic                  ls_we;
  logic [ADDR_W-1:0]     ls_addr;
  logic [DATA_W-1:0]     ls_wdata;
  logic [DATA_W/8-1:0]   ls_be;
  logic                  ls_ack;
  logic [DATA_W-1:0]     ls_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_ready;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  busy;

  modport master (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    input  mem_ready, mem_rdata,
    output if_ack, if_rdata, ls_ack, ls_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output busy
  );

  modport slave (
    output if_req, if_addr,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    output mem_ready, mem_rdata,
    input  if_ack, if_rdata, ls_ack, ls_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  busy
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ---- mem_arbiter : fetch / load-store arbiter onto one memory port -- rev 1.0 ----
// ---- optional fetch anti-starvation guard: MEM_ARB_STARVE_GUARD_EN ----
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  wire logic      clk,
  input  wire logic      reset,
  mem_arbiter_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BUS_IF  = 3'd1,
    S_BUS_LS  = 3'd2,
    S_RESP_IF = 3'd3,
    S_RESP_LS = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic [DATA_W/8-1:0]   r_mem_be;
  logic                  r_if_ack;
  logic                  r_ls_ack;
  logic [DATA_W-1:0]     r_if_rdata;
  logic [DATA_W-1:0]     r_ls_rdata;
  logic                  r_busy;

  logic                  w_grant_if;
  logic                  w_grant_ls;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);
  logic [3:0]            r_starve;

  // Counter only moves on grants, so it never exceeds STARVE_MAX.
  assign w_grant_if = bus.if_req && (!bus.ls_req || (r_starve == c_STARVE_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= 4'd0;
    end else if (r_state == S_IDLE) begin
      if (w_grant_if)
        r_starve <= 4'd0;
      else if (w_grant_ls)
        r_starve <= bus.if_req ? (r_starve + 4'd1) : 4'd0;
    end
  end
`else
  assign w_grant_if = bus.if_req && !bus.ls_req;
`endif

  assign w_grant_ls = bus.ls_req && !w_grant_if;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_if_ack    <= 1'b0;
      r_ls_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_ls_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_ls) begin
            r_state     <= S_BUS_LS;
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.ls_we;
            r_mem_addr  <= bus.ls_addr;
            r_mem_wdata <= bus.ls_wdata;
            r_mem_be    <= bus.ls_be;
            r_busy      <= 1'b1;
          end else if (w_grant_if) begin
            r_state     <= S_BUS_IF;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= bus.if_addr;
            r_mem_wdata <= '0;
            r_mem_be    <= '1;
            r_busy      <= 1'b1;
          end
        end
        S_BUS_IF: begin
          if (bus.mem_ready) begin
            r_state    <= S_RESP_IF;
            r_mem_req  <= 1'b0;
            r_if_rdata <= bus.mem_rdata;
            r_if_ack   <= 1'b1;
          end
        end
        S_BUS_LS: begin
          if (bus.mem_ready) begin
            r_state    <= S_RESP_LS;
            r_mem_req  <= 1'b0;
            r_ls_rdata <= bus.mem_rdata;
            r_ls_ack   <= 1'b1;
          end
        end
        S_RESP_IF, S_RESP_LS: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
  assign bus.if_ack    = r_if_ack;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ls_ack    = r_ls_ack;
  assign bus.ls_rdata  = r_ls_rdata;
  assign bus.busy      = r_busy;

endmodule

`default_nettype wire
